noise_gate: RTL

Per-sample downward noise gate for the 48 kHz channel strip. It sits directly downstream of the highpass stage and upstream of the phase stage, consuming `highpassOut` and producing the sample fed to `phaseIn`. A detector, attack/hold/release state machine and Q1.15 gain ramp mute the signal when its magnitude stays below a threshold, without zipper clicks.

---
 rtl/noise_gate.sv | 130 +++++++++++++
 1 files changed

// File: rtl/noise_gate.sv
// Per-sample downward noise gate: magnitude detector, attack/hold/release FSM and Q1.15 gain ramp.
// Optional NOISE_GATE_HYST_EN halves the threshold while the gate is OPEN or in HOLD.
module noise_gate #(
    parameter int unsigned HOLD_SAMPLES = 2400,
    parameter int unsigned ATTACK_STEP  = 2048,
    parameter int unsigned RELEASE_STEP = 128
) (
    input  logic               clk_48,
    input  logic               reset_n,
    input  logic signed [15:0] gateIn,
    input  logic        [14:0] threshold,
    output logic signed [15:0] gateOut,
    output logic               gateOpen
);

    localparam int unsigned HW       = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [15:0] GainFull = 16'h8000;

    typedef enum logic [2:0] {
        StClosed,
        StAttack,
        StOpen,
        StHold,
        StRelease
    } state_e;

    state_e                r_state, w_state_nxt;
    logic [15:0]           r_gain, w_gain_nxt;
    logic [HW-1:0]         r_hold, w_hold_nxt;

    logic [15:0]           w_neg;
    logic [14:0]           w_mag;
    logic [14:0]           w_thr;
    logic                  w_above;
    logic [31:0]           w_sum;
    logic [15:0]           w_gain_up;
    logic [15:0]           w_gain_dn;
    logic signed [32:0]    w_prod;
    logic signed [15:0]    w_out;

    // -32768 negates to 0x8000, which saturates to the largest 15-bit magnitude
    assign w_neg = ~gateIn + 16'd1;
    assign w_mag = !gateIn[15] ? gateIn[14:0] : (w_neg[15] ? 15'h7fff : w_neg[14:0]);

`ifdef NOISE_GATE_HYST_EN
    assign w_thr = (r_state == StOpen || r_state == StHold) ? (threshold >> 1) : threshold;
`else
    assign w_thr = threshold;
`endif

    assign w_above = (w_mag >= w_thr);

    assign w_sum     = 32'(r_gain) + ATTACK_STEP;
    assign w_gain_up = (w_sum >= 32'd32768) ? GainFull : 16'(w_sum);
    assign w_gain_dn = (32'(r_gain) > RELEASE_STEP) ? 16'(32'(r_gain) - RELEASE_STEP) : 16'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_hold_nxt  = r_hold;
        unique case (r_state)
            StClosed: begin
                w_gain_nxt = 16'd0;
                if (w_above) begin
                    w_state_nxt = StAttack;
                    w_gain_nxt  = w_gain_up;
                end
            end
            StAttack: begin
                w_gain_nxt = w_gain_up;
                if (w_gain_up == GainFull) begin
                    w_state_nxt = StOpen;
                end
            end
            StOpen: begin
                w_gain_nxt = GainFull;
                if (!w_above) begin
                    w_state_nxt = StHold;
                    w_hold_nxt  = HW'(HOLD_SAMPLES - 1);
                end
            end
            StHold: begin
                if (w_above) begin
                    w_state_nxt = StOpen;
                end else if (r_hold != '0) begin
                    w_hold_nxt = r_hold - 1'b1;
                end else begin
                    w_state_nxt = StRelease;
                    w_gain_nxt  = w_gain_dn;
                end
            end
            StRelease: begin
                if (w_above) begin
                    w_state_nxt = StAttack;
                    w_gain_nxt  = w_gain_up;
                end else begin
                    w_gain_nxt = w_gain_dn;
                    if (w_gain_dn == 16'd0) begin
                        w_state_nxt = StClosed;
                    end
                end
            end
            default: begin
                w_state_nxt = StClosed;
                w_gain_nxt  = 16'd0;
            end
        endcase
    end

    // Output uses the gain being written on this same edge
    assign w_prod = 33'(gateIn) * 33'($signed({1'b0, w_gain_nxt}));
    assign w_out  = 16'(w_prod >>> 15);

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StClosed;
            r_gain   <= 16'd0;
            r_hold   <= '0;
            gateOut  <= 16'sd0;
            gateOpen <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gain   <= w_gain_nxt;
            r_hold   <= w_hold_nxt;
            gateOut  <= w_out;
            gateOpen <= (w_state_nxt != StClosed);
        end
    end

endmodule
